int_rs_age: RTL and testbench

INT_RS_AGE -- requirements
Module: int_rs_age

---
 rtl/int_rs_age_if.sv | 41 ++++
 rtl/int_rs_age.sv | 153 +++++++++++++++
 tb/tb_int_rs_age.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_rs_age_if.sv
// Dispatch, CDB wakeup and issue signals of the integer reservation station.
// The slave modport is the station's view; the master modport is its environment.
interface int_rs_age_if #(
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int ROB_IDX   = 5,
  parameter int PAYLOAD_W = 64
);
  logic                           disp_valid;
  logic                           disp_ready;
  logic [PRF_IDX-1:0]             disp_rs1_phy;
  logic [PRF_IDX-1:0]             disp_rs2_phy;
  logic                           disp_rs1_rdy;
  logic                           disp_rs2_rdy;
  logic                           disp_rs1_used;
  logic                           disp_rs2_used;
  logic [ROB_IDX-1:0]             disp_rob_id;
  logic [PAYLOAD_W-1:0]           disp_payload;
  logic [CDB_WIDTH-1:0]           cdb_valid;
  logic [CDB_WIDTH*PRF_IDX-1:0]   cdb_rd_phy;
  logic                           iss_valid;
  logic                           iss_ready;
  logic [PRF_IDX-1:0]             iss_rs1_phy;
  logic [PRF_IDX-1:0]             iss_rs2_phy;
  logic [ROB_IDX-1:0]             iss_rob_id;
  logic [PAYLOAD_W-1:0]           iss_payload;

  modport master (
    output disp_valid, disp_rs1_phy, disp_rs2_phy, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_used, disp_rs2_used, disp_rob_id, disp_payload,
           cdb_valid, cdb_rd_phy, iss_ready,
    input  disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_rob_id, iss_payload
  );

  modport slave (
    input  disp_valid, disp_rs1_phy, disp_rs2_phy, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_used, disp_rs2_used, disp_rob_id, disp_payload,
           cdb_valid, cdb_rd_phy, iss_ready,
    output disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_rob_id, iss_payload
  );
endinterface

// File: rtl/int_rs_age.sv
// Age-ordered integer reservation station: oldest-ready select via an age matrix.
// Optional INT_RS_CDB_SELECT_BYPASS_EN lets same-cycle CDB wakeups feed select.
module int_rs_age #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int ROB_IDX   = 5,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  int_rs_age_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q, rs1_rdy_q, rs2_rdy_q;
  logic [PRF_IDX-1:0]   rs1_phy_q [DEPTH];
  logic [PRF_IDX-1:0]   rs2_phy_q [DEPTH];
  logic [ROB_IDX-1:0]   rob_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  // older_q[i][j] set means entry i was written before entry j
  logic [DEPTH-1:0]     older_q [DEPTH];

  logic [DEPTH-1:0]     rs1_wake, rs2_wake, cand, sel;
  logic [IDX_W-1:0]     sel_idx, free_idx;
  logic                 found, accept, load, take;
  logic                 disp_r1, disp_r2;
  logic [OCC_W-1:0]     occ_q;
  logic                 iss_valid_q;
  logic [PRF_IDX-1:0]   iss_rs1_q, iss_rs2_q;
  logic [ROB_IDX-1:0]   iss_rob_q;
  logic [PAYLOAD_W-1:0] iss_payload_q;

  function automatic logic cdb_hit(input logic [PRF_IDX-1:0] tag,
                                   input logic [CDB_WIDTH-1:0] cv,
                                   input logic [CDB_WIDTH*PRF_IDX-1:0] cp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++)
      if (cv[k] && cp[k*PRF_IDX +: PRF_IDX] == tag) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    rs1_wake = '0;
    rs2_wake = '0;
    cand     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_wake[i] = cdb_hit(rs1_phy_q[i], bus.cdb_valid, bus.cdb_rd_phy);
      rs2_wake[i] = cdb_hit(rs2_phy_q[i], bus.cdb_valid, bus.cdb_rd_phy);
`ifdef INT_RS_CDB_SELECT_BYPASS_EN
      cand[i] = valid_q[i] && (rs1_rdy_q[i] || rs1_wake[i]) && (rs2_rdy_q[i] || rs2_wake[i]);
`else
      cand[i] = valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i];
`endif
    end
  end

  // A candidate wins when no other candidate is older than it
  always_comb begin
    sel      = '0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = cand[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && older_q[j][i]) sel[i] = 1'b0;
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (sel[i]) sel_idx = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign found          = |cand;
  assign bus.disp_ready = (occ_q < OCC_W'(DEPTH));
  assign accept         = bus.disp_valid && bus.disp_ready && !flush;
  assign load           = !iss_valid_q || bus.iss_ready;
  assign take           = load && found && !flush;
  assign disp_r1 = bus.disp_rs1_rdy || !bus.disp_rs1_used ||
                   cdb_hit(bus.disp_rs1_phy, bus.cdb_valid, bus.cdb_rd_phy);
  assign disp_r2 = bus.disp_rs2_rdy || !bus.disp_rs2_used ||
                   cdb_hit(bus.disp_rs2_phy, bus.cdb_valid, bus.cdb_rd_phy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      rs1_rdy_q <= rs1_rdy_q | rs1_wake;
      rs2_rdy_q <= rs2_rdy_q | rs2_wake;
      if (take) valid_q[sel_idx] <= 1'b0;
      if (accept) begin
        valid_q[free_idx]   <= 1'b1;
        rs1_rdy_q[free_idx] <= disp_r1;
        rs2_rdy_q[free_idx] <= disp_r2;
        for (int j = 0; j < DEPTH; j++)
          if (IDX_W'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
        older_q[free_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rs1_phy_q[free_idx] <= bus.disp_rs1_phy;
      rs2_phy_q[free_idx] <= bus.disp_rs2_phy;
      rob_q[free_idx]     <= bus.disp_rob_id;
      payload_q[free_idx] <= bus.disp_payload;
    end
  end

  // Issue slot only reloads when empty or being consumed, so data holds under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_q   <= 1'b0;
      iss_rs1_q     <= '0;
      iss_rs2_q     <= '0;
      iss_rob_q     <= '0;
      iss_payload_q <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (load) begin
      iss_valid_q <= found;
      if (found) begin
        iss_rs1_q     <= rs1_phy_q[sel_idx];
        iss_rs2_q     <= rs2_phy_q[sel_idx];
        iss_rob_q     <= rob_q[sel_idx];
        iss_payload_q <= payload_q[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_q + OCC_W'(accept) - OCC_W'(take);
  end

  assign occupancy       = occ_q;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_rs1_phy = iss_rs1_q;
  assign bus.iss_rs2_phy = iss_rs2_q;
  assign bus.iss_rob_id  = iss_rob_q;
  assign bus.iss_payload = iss_payload_q;
endmodule

// File: tb/tb_int_rs_age.sv
// Scoreboard bench for int_rs_age: expected issues are queued at dispatch
// and checked in order whenever the issue handshake completes.
module tb_int_rs_age;
`ifdef INT_RS_CDB_SELECT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0] rob;
    logic [5:0] rs1;
    logic [5:0] rs2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] occupancy;
  int         assert_count;
  int         fail_count;
  exp_t       sb[$];

  int_rs_age_if #(.CDB_WIDTH(2), .PRF_IDX(6), .ROB_IDX(5), .PAYLOAD_W(64)) bus ();

  int_rs_age #(.DEPTH(8), .CDB_WIDTH(2), .PRF_IDX(6), .ROB_IDX(5), .PAYLOAD_W(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pay(input logic [4:0] rob);
    return {27'h5A5A5A5, rob, 27'h0123456, ~rob};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rob, input logic [5:0] rs1, input logic r1, input logic u1,
                               input logic [5:0] rs2, input logic r2, input logic u2, input bit expect_issue);
    exp_t e;
    bus.disp_valid    = 1'b1;
    bus.disp_rob_id   = rob;
    bus.disp_rs1_phy  = rs1;
    bus.disp_rs1_rdy  = r1;
    bus.disp_rs1_used = u1;
    bus.disp_rs2_phy  = rs2;
    bus.disp_rs2_rdy  = r2;
    bus.disp_rs2_used = u2;
    bus.disp_payload  = pay(rob);
    if (expect_issue) begin
      e.rob = rob;
      e.rs1 = rs1;
      e.rs2 = rs2;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (occupancy == 4'd0 && !bus.iss_valid) done = 1'b1;
    end
    checkOutput(tag, done, 1'b1);
  endtask

  // Every completed issue handshake must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.iss_valid && bus.iss_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_issue", {59'd0, bus.iss_rob_id}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("iss_rob", bus.iss_rob_id, e.rob);
        checkOutput("iss_rs1", bus.iss_rs1_phy, e.rs1);
        checkOutput("iss_rs2", bus.iss_rs2_phy, e.rs2);
        checkOutput("iss_payload", bus.iss_payload, pay(e.rob));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_rob_id = '0;
    bus.disp_rs1_phy = '0;
    bus.disp_rs2_phy = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs1_used = 1'b0;
    bus.disp_rs2_used = 1'b0;
    bus.disp_payload = '0;
    bus.cdb_valid = '0;
    bus.cdb_rd_phy = '0;
    bus.iss_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_iss_valid", bus.iss_valid, 1'b0);
    checkOutput("rst_occupancy", occupancy, 4'd0);
    checkOutput("rst_disp_ready", bus.disp_ready, 1'b1);
    checkOutput("rst_iss_rob", bus.iss_rob_id, 5'd0);
    rst = 1'b1;

    $display("[TB] basic dispatch to issue");
    bus.iss_ready = 1'b1;
    applyStimulus(5'd3, 6'd1, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    checkOutput("basic_occ_after_disp", occupancy, 4'd1);
    checkOutput("basic_not_yet_valid", bus.iss_valid, 1'b0);
    tick();
    checkOutput("basic_iss_valid", bus.iss_valid, 1'b1);
    checkOutput("basic_iss_rob", bus.iss_rob_id, 5'd3);
    checkOutput("basic_occ_zero", occupancy, 4'd0);
    tick();
    checkOutput("basic_slot_empty", bus.iss_valid, 1'b0);

    $display("[TB] ready-younger passes stalled older, then wakeup");
    applyStimulus(5'd1, 6'd9, 1'b0, 1'b1, 6'd4, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd2, 6'd5, 1'b1, 1'b1, 6'd6, 1'b1, 1'b1, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    applyStimulus(5'd1, 6'd9, 1'b0, 1'b1, 6'd4, 1'b1, 1'b1, 1'b1);
    bus.disp_valid = 1'b0;
    checkOutput("wake_none_yet", bus.iss_valid, 1'b0);
    tick();
    checkOutput("wake_rob2_first", bus.iss_rob_id, 5'd2);
    checkOutput("wake_occ_one", occupancy, 4'd1);
    bus.cdb_valid = 2'b01;
    bus.cdb_rd_phy = {6'd0, 6'd9};
    tick();
    bus.cdb_valid = 2'b00;
    checkOutput("wake_edge1_valid", bus.iss_valid, BYP);
    tick();
    checkOutput("wake_edge2_valid", bus.iss_valid, !BYP);
    tick();
    checkOutput("wake_done_valid", bus.iss_valid, 1'b0);
    checkOutput("wake_done_occ", occupancy, 4'd0);

    $display("[TB] full array under backpressure");
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) applyStimulus(5'd10, 6'd20, 1'b0, 1'b1, 6'd21, 1'b1, 1'b1, 1'b0);
      else        applyStimulus(5'(10 + i), 6'(30 + i), 1'b1, 1'b1, 6'(40 + i), 1'b0, 1'b0, 1'b1);
      checkOutput("fill_disp_ready", bus.disp_ready, 1'b1);
      tick();
    end
    applyStimulus(5'd19, 6'd50, 1'b1, 1'b1, 6'd51, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_disp_ready", bus.disp_ready, 1'b0);
      checkOutput("full_occ", occupancy, 4'd8);
      checkOutput("full_hold_rob", bus.iss_rob_id, 5'd11);
      checkOutput("full_hold_payload", bus.iss_payload, pay(5'd11));
      tick();
    end
    bus.disp_valid = 1'b0;
    sb.push_back('{rob: 5'd10, rs1: 6'd20, rs2: 6'd21});
    bus.iss_ready = 1'b1;
    tick();
    checkOutput("full_release_occ", occupancy, 4'd7);
    checkOutput("full_release_rob", bus.iss_rob_id, 5'd12);
    repeat (6) tick();
    checkOutput("full_only_stalled_left", occupancy, 4'd1);
    checkOutput("full_last_ready_rob", bus.iss_rob_id, 5'd18);
    bus.cdb_valid = 2'b10;
    bus.cdb_rd_phy = {6'd20, 6'd0};
    tick();
    bus.cdb_valid = 2'b00;
    drain("full_drain");

    $display("[TB] same-cycle CDB capture at dispatch");
    applyStimulus(5'd5, 6'd12, 1'b0, 1'b1, 6'd3, 1'b1, 1'b1, 1'b1);
    bus.cdb_valid = 2'b10;
    bus.cdb_rd_phy = {6'd12, 6'd0};
    tick();
    bus.disp_valid = 1'b0;
    bus.cdb_valid = 2'b00;
    tick();
    checkOutput("capture_iss_valid", bus.iss_valid, 1'b1);
    checkOutput("capture_iss_rob", bus.iss_rob_id, 5'd5);
    applyStimulus(5'd6, 6'd7, 1'b1, 1'b1, 6'd14, 1'b0, 1'b1, 1'b0);
    bus.cdb_valid = 2'b01;
    bus.cdb_rd_phy = {6'd14, 6'd15};
    tick();
    bus.disp_valid = 1'b0;
    bus.cdb_valid = 2'b00;
    tick();
    checkOutput("invalid_chan_no_wake", bus.iss_valid, 1'b0);
    checkOutput("invalid_chan_occ", occupancy, 4'd1);
    applyStimulus(5'd7, 6'd40, 1'b0, 1'b0, 6'd8, 1'b1, 1'b1, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    checkOutput("unused_src_rob", bus.iss_rob_id, 5'd7);
    sb.push_back('{rob: 5'd6, rs1: 6'd7, rs2: 6'd14});
    bus.cdb_valid = 2'b01;
    bus.cdb_rd_phy = {6'd0, 6'd14};
    tick();
    bus.cdb_valid = 2'b00;
    drain("capture_drain");

    $display("[TB] flush with pending dispatch");
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'(20 + i), 6'(i + 1), 1'b1, 1'b1, 6'(i + 2), 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("preflush_occ", occupancy, 4'd4);
    checkOutput("preflush_iss_valid", bus.iss_valid, 1'b1);
    applyStimulus(5'd25, 6'd1, 1'b1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    checkOutput("flush_occ", occupancy, 4'd0);
    checkOutput("flush_iss_valid", bus.iss_valid, 1'b0);
    bus.iss_ready = 1'b1;
    tick();
    tick();
    checkOutput("flush_dropped_occ", occupancy, 4'd0);
    checkOutput("flush_dropped_valid", bus.iss_valid, 1'b0);

    $display("[TB] asynchronous reset with full array");
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(5'(i), 6'(i), 1'b1, 1'b1, 6'(i + 9), 1'b1, 1'b1, 1'b0);
      tick();
    end
    bus.disp_valid = 1'b0;
    checkOutput("prereset_occ", occupancy, 4'd8);
    checkOutput("prereset_disp_ready", bus.disp_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_iss_valid", bus.iss_valid, 1'b0);
    checkOutput("async_rst_occ", occupancy, 4'd0);
    checkOutput("async_rst_disp_ready", bus.disp_ready, 1'b1);
    checkOutput("async_rst_iss_rob", bus.iss_rob_id, 5'd0);
    checkOutput("async_rst_payload", bus.iss_payload, 64'd0);
    tick();
    rst = 1'b1;
    bus.iss_ready = 1'b1;
    applyStimulus(5'd30, 6'd33, 1'b1, 1'b1, 6'd34, 1'b1, 1'b1, 1'b1);
    tick();
    bus.disp_valid = 1'b0;
    checkOutput("post_rst_occ", occupancy, 4'd1);
    tick();
    checkOutput("post_rst_iss_rob", bus.iss_rob_id, 5'd30);
    tick();
    checkOutput("post_rst_empty", bus.iss_valid, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
